// File: rtl/clk_divider_pkg.sv
// Shared helpers for the clock divider: counter width derivation.
package clk_divider_pkg;

   // Width of a counter that must hold 0..d-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned d);
      return (d <= 2) ? 1 : $clog2(d);
   endfunction

endpackage

// File: rtl/clk_divider.sv
// Free-running integer clock divider with registered, glitch-free clk_out and
// single-cycle strobes aligned to each rising and falling edge of clk_out.
module clk_divider
   import clk_divider_pkg::*;
#(
   parameter int unsigned DIVISOR = 50
)
(
   input  logic clk_in,
   input  logic rst_n,
   output logic clk_out,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int unsigned CNT_W    = cnt_width(DIVISOR);
   localparam int unsigned HIGH_CNT = DIVISOR / 2;
   localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(DIVISOR - 1);
   localparam logic [CNT_W-1:0] HIGH_VAL = CNT_W'(HIGH_CNT);

   generate
      if (DIVISOR < 2) begin : g_bad_divisor
         $error("clk_divider: DIVISOR must be at least 2");
      end
   endgenerate

   logic [CNT_W-1:0] count_q, count_d;
   logic             clk_out_q, clk_out_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   // Outputs decode the pre-update count, so they trail the counter by one edge.
   always_comb begin
      count_d   = (count_q == LAST_VAL) ? '0 : count_q + CNT_W'(1);
      clk_out_d = (count_q < HIGH_VAL);
      rise_d    = (count_q == '0);
      fall_d    = (count_q == HIGH_VAL);
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         clk_out_q <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         clk_out_q <= clk_out_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
      end
   end

   assign clk_out    = clk_out_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

endmodule

// File: tb/tb_clk_divider.sv
// Bench for clk_divider: three ratios (50, 5, 2) side by side under random run
// lengths and random asynchronous resets, compared to an arithmetic phase model.
module tb_clk_divider;

   logic clk_in;
   logic rst_n;
   logic co50, r50, f50;
   logic co5,  r5,  f5;
   logic co2,  r2,  f2;

   int total;
   int bad;
   int edgeNum;

   clk_divider #(.DIVISOR(50)) dut50 (
      .clk_in(clk_in), .rst_n(rst_n),
      .clk_out(co50), .rise_pulse(r50), .fall_pulse(f50)
   );
   clk_divider #(.DIVISOR(5)) dut5 (
      .clk_in(clk_in), .rst_n(rst_n),
      .clk_out(co5), .rise_pulse(r5), .fall_pulse(f5)
   );
   clk_divider #(.DIVISOR(2)) dut2 (
      .clk_in(clk_in), .rst_n(rst_n),
      .clk_out(co2), .rise_pulse(r2), .fall_pulse(f2)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Expected {clk_out, rise, fall} for edge k after release (k=0 means in reset).
   function automatic logic [2:0] model(input int d, input int k);
      int ph;
      if (k == 0) return 3'b000;
      ph = (k - 1) % d;
      return {ph < (d / 2), ph == 0, ph == (d / 2)};
   endfunction

   task automatic checkOne(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s edge=%0d observed={clk,rise,fall}=%b expected=%b",
                tag, edgeNum, obs, exp);
      end
   endtask

   task automatic checkOutput();
      checkOne("div50", {co50, r50, f50}, model(50, edgeNum));
      checkOne("div5",  {co5,  r5,  f5},  model(5,  edgeNum));
      checkOne("div2",  {co2,  r2,  f2},  model(2,  edgeNum));
   endtask

   // Advance one clk_in edge and check shortly after it.
   task automatic applyStimulus(input bit running);
      @(posedge clk_in);
      #1;
      if (running) edgeNum++;
      checkOutput();
   endtask

   initial begin
      int runLen;
      int holdLen;
      total   = 0;
      bad     = 0;
      edgeNum = 0;
      rst_n   = 1'b0;

      // Reset hold: everything stays low for ten edges.
      #1;
      checkOutput();
      for (int i = 0; i < 10; i++) applyStimulus(1'b0);

      for (int seg = 0; seg < 4; seg++) begin
         // Release mid-cycle so the next edge is unambiguously the first counted one.
         #2;
         rst_n   = 1'b1;
         edgeNum = 0;
         if (seg == 0) runLen = 110 + int'($urandom_range(0, 40));
         else          runLen = 20 + int'($urandom_range(0, 90));
         for (int i = 0; i < runLen; i++) applyStimulus(1'b1);

         // Asynchronous mid-period reset: outputs must drop before any edge.
         #2;
         rst_n   = 1'b0;
         #1;
         edgeNum = 0;
         checkOutput();
         holdLen = 1 + int'($urandom_range(0, 4));
         for (int i = 0; i < holdLen; i++) applyStimulus(1'b0);
      end

      // Final stretch verifying the full 50-cycle period after a reset.
      #2;
      rst_n   = 1'b1;
      edgeNum = 0;
      for (int i = 0; i < 105; i++) applyStimulus(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
